// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types and widths for the FIFO write-port arbiter.
//   state_t : arbiter FSM states (IDLE, BURST)
//   OCC_W   : occupancy counter width for the default depth
//   PTR_W   : requester index width for the default requester count
//   BEAT_W  : burst beat counter width (covers MAX_BURST up to 15)
// The top module derives its own widths from its parameters. The OCC_W and
// PTR_W values here match the default configuration.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam int DEF_N_REQ = 4;
  localparam int DEF_DEPTH = 8;
  localparam int OCC_W     = $clog2(DEF_DEPTH + 1);
  localparam int PTR_W     = $clog2(DEF_N_REQ);
  localparam int BEAT_W    = 4;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational rotating-priority search.
//   req   in  N      request vector
//   ptr   in  PTR_W  index with highest priority this cycle
//   idx   out PTR_W  first requesting index in order ptr, ptr+1, ... mod N
//   valid out 1      at least one request is present
module rr_pick #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [PTR_W-1:0] idx,
  output logic             valid
);

  logic [PTR_W-1:0] j;

  // The loop runs from the lowest priority to the highest. The last hit
  // wins, so the search order starts at ptr.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    j     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = PTR_W'((int'(ptr) + k) % N);
      if (req[j]) begin
        idx   = j;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: shares one synchronous FIFO write port among N_REQ
// producers. It uses round-robin arbitration with bursts of up to
// MAX_BURST beats. A shadow occupancy count keeps writes out of a full FIFO.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   req, req_data   per-producer request and data (slice i at [i*WIDTH +: WIDTH])
//   gnt             one-hot; a beat of requester i is accepted this cycle
//   fifo_wr_en      write strobe to the FIFO
//   fifo_data_in    write data to the FIFO (0 when not writing)
//   fifo_rd_en      copy of the consumer's FIFO read enable
//   fifo_empty      FIFO empty flag
//   occupancy       shadow entry count
//   busy            high while a burst owner holds the port
//   wr_beats        (FIFO_ARB_STATS_EN only) saturating count of accepted beats
//   full_stalls     (FIFO_ARB_STATS_EN only) saturating count of full stalls
//
// Handshake: a producer raises req[i] and holds req_data stable until it
// sees gnt[i]. A beat transfers in exactly the cycle where gnt[i] is high.
// The producer may then present the next word or drop req.
//
// Optional feature macro: FIFO_ARB_STATS_EN (adds wr_beats / full_stalls).
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req,
  input  logic [N_REQ*WIDTH-1:0]       req_data,
  output logic [N_REQ-1:0]             gnt,
  output logic                         fifo_wr_en,
  output logic [WIDTH-1:0]             fifo_data_in,
  input  logic                         fifo_rd_en,
  input  logic                         fifo_empty,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic                         busy
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [15:0]                  wr_beats,
  output logic [15:0]                  full_stalls
`endif
);

  localparam int OCC_BITS = $clog2(DEPTH + 1);
  localparam int PTR_BITS = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t                state_q, state_d;
  logic [PTR_BITS-1:0]   owner_q, owner_d;
  logic [PTR_BITS-1:0]   rr_q, rr_d;
  logic [BEAT_W-1:0]     beats_q, beats_d;
  logic [OCC_BITS-1:0]   occ_q;

  logic [PTR_BITS-1:0]   pick_idx;
  logic                  pick_valid;
  logic                  owner_req;
  logic                  has_room;
  logic                  accept;
  logic                  last_beat;
  logic [PTR_BITS-1:0]   next_ptr;
  logic                  inc;
  logic                  dec;

  rr_pick #(
    .N     (N_REQ),
    .PTR_W (PTR_BITS)
  ) u_rr_pick (
    .req   (req),
    .ptr   (rr_q),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  // The FIFO's own full flag lags by a cycle, so the room check uses the
  // shadow count. That count already includes every write issued so far.
  assign owner_req = req[owner_q];
  assign has_room  = occ_q < OCC_BITS'(DEPTH);
  assign accept    = (state_q == BURST) && owner_req && has_room;
  assign last_beat = beats_q == BEAT_W'(MAX_BURST - 1);
  assign next_ptr  = (owner_q == PTR_BITS'(N_REQ - 1)) ? '0 : owner_q + 1'b1;

  assign inc = fifo_wr_en;
  assign dec = fifo_rd_en && !fifo_empty;

  assign occupancy = occ_q;
  assign busy      = (state_q == BURST);

  // Write-port outputs depend on registered state plus req only. An
  // asynchronous reset therefore drops them at once.
  always_comb begin
    gnt          = '0;
    fifo_wr_en   = accept;
    fifo_data_in = '0;
    if (accept) begin
      gnt[owner_q] = 1'b1;
      fifo_data_in = req_data[owner_q*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    beats_d = beats_q;
    case (state_q)
      IDLE: begin
        // Arbitration cycle: nothing is written here.
        if (pick_valid) begin
          owner_d = pick_idx;
          beats_d = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        if (accept) begin
          beats_d = beats_q + 1'b1;
          if (last_beat) begin
            state_d = IDLE;
            rr_d    = next_ptr;
          end
        end else if (!owner_req) begin
          // The owner gave up early. It forfeits the rest of its burst.
          state_d = IDLE;
          rr_d    = next_ptr;
        end
        // Otherwise the FIFO is full: hold the burst and stall.
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_q    <= '0;
      beats_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      beats_q <= beats_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q <= '0;
    end else begin
      case ({inc, dec})
        2'b10:   occ_q <= occ_q + 1'b1;
        2'b01:   occ_q <= occ_q - 1'b1;
        default: occ_q <= occ_q;
      endcase
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic full_stall;
  assign full_stall = (state_q == BURST) && owner_req && (occ_q == OCC_BITS'(DEPTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_beats    <= '0;
      full_stalls <= '0;
    end else begin
      if (accept && (wr_beats != 16'hFFFF))
        wr_beats <= wr_beats + 16'd1;
      if (full_stall && (full_stalls != 16'hFFFF))
        full_stalls <= full_stalls + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: bench for fifo_wr_arbiter (default parameters).
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int D  = 8;
  localparam int MB = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   gnt;
  logic           fifo_wr_en;
  logic [W-1:0]   fifo_data_in;
  logic           fifo_rd_en = 1'b0;
  logic           fifo_empty = 1'b1;
  logic [3:0]     occupancy;
  logic           busy;
`ifdef FIFO_ARB_STATS_EN
  logic [15:0]    wr_beats;
  logic [15:0]    full_stalls;
`endif

  int n_cmp = 0;
  int n_err = 0;

  fifo_wr_arbiter #(.N_REQ(N), .WIDTH(W), .DEPTH(D), .MAX_BURST(MB)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_data     (req_data),
    .gnt          (gnt),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_data_in (fifo_data_in),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_empty   (fifo_empty),
    .occupancy    (occupancy),
    .busy         (busy)
`ifdef FIFO_ARB_STATS_EN
    ,
    .wr_beats     (wr_beats),
    .full_stalls  (full_stalls)
`endif
  );

  // ---------------- producers ----------------
  // Each producer keeps a queue of words and requests while the queue is
  // not empty. The front word is presented until a grant is seen.
  logic [W-1:0] src_q[N][$];
  logic [N-1:0] req_pend = '0;
  logic [N-1:0] mask     = '0;
  logic [N-1:0] g_seen   = '0;
  logic [W-1:0] dat[N];

  assign req      = req_pend & ~mask;
  assign req_data = {dat[3], dat[2], dat[1], dat[0]};

  initial for (int i = 0; i < N; i++) dat[i] = '0;

  always @(negedge clk) g_seen = gnt;

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++) begin
      if (g_seen[i] && !rst && src_q[i].size() > 0) void'(src_q[i].pop_front());
      req_pend[i] = src_q[i].size() > 0;
      dat[i]      = (src_q[i].size() > 0) ? src_q[i][0] : '0;
    end
  end

  task automatic push(input int i, input logic [W-1:0] d);
    src_q[i].push_back(d);
    req_pend[i] = 1'b1;
    dat[i]      = src_q[i][0];
  endtask

  task automatic clear_src();
    for (int i = 0; i < N; i++) begin
      src_q[i].delete();
      dat[i] = '0;
    end
    req_pend = '0;
    mask     = '0;
  endtask

  // ---------------- reference model + scoreboard ----------------
  // Transaction-level view: who owns the port, how many beats are left,
  // where the rotation points, and how many words the FIFO holds.
  bit           m_burst = 0, n_burst = 0;
  int           m_owner = 0, n_owner = 0;
  int           m_rr = 0, n_rr = 0;
  int           m_left = 0, n_left = 0;
  int           m_occ = 0, n_occ = 0;
  bit           acc;
  bit           found;
  logic [N-1:0] e_gnt;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] e_data;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_burst = 0; m_owner = 0; m_rr = 0; m_left = 0; m_occ = 0;
      exp_q.delete();
    end else begin
      m_burst = n_burst; m_owner = n_owner; m_rr = n_rr; m_left = n_left; m_occ = n_occ;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      n_burst = 0; n_owner = 0; n_rr = 0; n_left = 0; n_occ = 0;
    end else begin
      acc   = m_burst && req[m_owner] && (m_occ < D);
      e_gnt = '0;
      if (acc) e_gnt[m_owner] = 1'b1;
      n_cmp++;
      if (gnt !== e_gnt) begin
        n_err++; $display("FAIL mon_gnt t=%0t got %b exp %b", $time, gnt, e_gnt);
      end
      n_cmp++;
      if (fifo_wr_en !== acc) begin
        n_err++; $display("FAIL mon_wr_en t=%0t got %b exp %b", $time, fifo_wr_en, acc);
      end
      n_cmp++;
      if (occupancy !== 4'(m_occ)) begin
        n_err++; $display("FAIL mon_occ t=%0t got %0d exp %0d", $time, occupancy, m_occ);
      end
      n_cmp++;
      if (busy !== m_burst) begin
        n_err++; $display("FAIL mon_busy t=%0t got %b exp %b", $time, busy, m_burst);
      end
      if (acc) exp_q.push_back(dat[m_owner]);
      if (fifo_wr_en === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL mon_data t=%0t got %h exp none", $time, fifo_data_in);
        end else begin
          e_data = exp_q.pop_front();
          if (fifo_data_in !== e_data) begin
            n_err++; $display("FAIL mon_data t=%0t got %h exp %h", $time, fifo_data_in, e_data);
          end
        end
      end else begin
        n_cmp++;
        if (fifo_data_in !== '0) begin
          n_err++; $display("FAIL mon_data_idle t=%0t got %h exp 00", $time, fifo_data_in);
        end
      end

      // Next transaction-level state.
      n_occ   = m_occ + (acc ? 1 : 0) - ((fifo_rd_en && !fifo_empty) ? 1 : 0);
      n_burst = m_burst; n_owner = m_owner; n_rr = m_rr; n_left = m_left;
      if (!m_burst) begin
        found = 0;
        for (int k = 0; k < N; k++) begin
          if (!found && req[(m_rr + k) % N]) begin
            found = 1; n_owner = (m_rr + k) % N;
          end
        end
        if (found) begin
          n_burst = 1; n_left = MB;
        end
      end else if (acc) begin
        n_left = m_left - 1;
        if (n_left == 0) begin
          n_burst = 0; n_rr = (m_owner + 1) % N;
        end
      end else if (!req[m_owner]) begin
        n_burst = 0; n_rr = (m_owner + 1) % N;
      end
    end
  end

  // ---------------- driver tasks / scenarios ----------------
  task automatic do_reset();
    rst = 1'b1;
    clear_src();
    fifo_rd_en = 1'b0;
    fifo_empty = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    push(0, 8'h11);
    #1;
    n_cmp++; if (gnt !== '0) begin n_err++; $display("FAIL rst_gnt got %b exp 0000", gnt); end
    n_cmp++; if (fifo_wr_en !== 1'b0) begin n_err++; $display("FAIL rst_wr_en got %b exp 0", fifo_wr_en); end
    n_cmp++; if (fifo_data_in !== '0) begin n_err++; $display("FAIL rst_data got %h exp 00", fifo_data_in); end
    n_cmp++; if (occupancy !== '0) begin n_err++; $display("FAIL rst_occ got %0d exp 0", occupancy); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b exp 0", busy); end
    @(posedge clk); #2;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy_edge got %b exp 0", busy); end
  endtask

  task automatic test_single_burst();
    logic [N-1:0] eg[9];
    logic [W-1:0] ed[9];
    eg = '{4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 4'b0100, 4'b0000};
    ed = '{8'h00, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'h00, 8'hA4, 8'hA5, 8'h00};
    do_reset();
    @(posedge clk); #2;
    for (int k = 0; k < 6; k++) push(2, 8'hA0 + 8'(k));
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      n_cmp++;
      if (gnt !== eg[c] || fifo_data_in !== ed[c]) begin
        n_err++;
        $display("FAIL single_c%0d got gnt=%b data=%h exp gnt=%b data=%h", c, gnt, fifo_data_in, eg[c], ed[c]);
      end
    end
  endtask

  task automatic test_full_stall();
    int order[$];
    do_reset();
    @(posedge clk); #2;
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 12; k++) push(i, 8'((i << 4) | k));
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) if (gnt[i]) order.push_back(i);
    end
    n_cmp++;
    if (order.size() != 8) begin
      n_err++; $display("FAIL full_grant_count got %0d exp 8", order.size());
    end else begin
      for (int j = 0; j < 8; j++) begin
        n_cmp++;
        if (order[j] != j / 4) begin
          n_err++; $display("FAIL full_order_%0d got %0d exp %0d", j, order[j], j / 4);
        end
      end
    end
    n_cmp++; if (occupancy !== 4'd8) begin n_err++; $display("FAIL full_occ got %0d exp 8", occupancy); end
    n_cmp++; if (fifo_wr_en !== 1'b0) begin n_err++; $display("FAIL full_wr_en got %b exp 0", fifo_wr_en); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL full_busy got %b exp 1", busy); end
    n_cmp++; if (gnt !== '0) begin n_err++; $display("FAIL full_gnt got %b exp 0000", gnt); end
    // One read frees one slot; requester 2 takes it on the following cycle.
    @(posedge clk); #2;
    fifo_rd_en = 1'b1; fifo_empty = 1'b0;
    @(posedge clk); #2;
    fifo_rd_en = 1'b0;
    @(negedge clk);
    n_cmp++; if (occupancy !== 4'd7) begin n_err++; $display("FAIL rd_occ got %0d exp 7", occupancy); end
    n_cmp++; if (gnt !== 4'b0100) begin n_err++; $display("FAIL rd_gnt got %b exp 0100", gnt); end
    @(negedge clk);
    n_cmp++; if (occupancy !== 4'd8) begin n_err++; $display("FAIL refill_occ got %0d exp 8", occupancy); end
    n_cmp++; if (gnt !== '0) begin n_err++; $display("FAIL refill_gnt got %b exp 0000", gnt); end
  endtask

  task automatic test_rw_same_cycle();
    int seen;
    bit hit;
    do_reset();
    @(posedge clk); #2;
    for (int k = 0; k < 5; k++) push(0, 8'h50 + 8'(k));
    seen = 0;
    for (int t = 0; t < 20 && seen < 3; t++) begin
      @(negedge clk);
      if (gnt[0]) seen++;
    end
    n_cmp++; if (seen != 3) begin n_err++; $display("FAIL rw_timeout got %0d grants exp 3", seen); end
    @(posedge clk); #2;
    fifo_rd_en = 1'b1; fifo_empty = 1'b0;
    @(negedge clk);
    n_cmp++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL rw_gnt got %b exp 0001", gnt); end
    n_cmp++; if (occupancy !== 4'd3) begin n_err++; $display("FAIL rw_occ_pre got %0d exp 3", occupancy); end
    @(posedge clk); #2;
    fifo_rd_en = 1'b0;
    @(negedge clk);
    n_cmp++; if (occupancy !== 4'd3) begin n_err++; $display("FAIL rw_occ_post got %0d exp 3", occupancy); end
    hit = 0;
    for (int t = 0; t < 10 && !hit; t++) begin
      @(negedge clk);
      if (gnt[0]) hit = 1;
    end
    n_cmp++; if (!hit) begin n_err++; $display("FAIL rw_beat5_timeout got none exp gnt"); end
    @(posedge clk); #2;
    fifo_rd_en = 1'b1; fifo_empty = 1'b1;
    @(posedge clk); #2;
    fifo_rd_en = 1'b0; fifo_empty = 1'b0;
    @(negedge clk);
    n_cmp++; if (occupancy !== 4'd4) begin n_err++; $display("FAIL empty_rd_occ got %0d exp 4", occupancy); end
  endtask

  task automatic test_drop();
    int seen;
    bit hit;
    do_reset();
    @(posedge clk); #2;
    for (int k = 0; k < 5; k++) push(1, 8'h20 + 8'(k));
    for (int k = 0; k < 3; k++) push(3, 8'h30 + 8'(k));
    seen = 0;
    for (int t = 0; t < 20 && seen < 2; t++) begin
      @(negedge clk);
      if (gnt[1]) seen++;
    end
    n_cmp++; if (seen != 2) begin n_err++; $display("FAIL drop_timeout got %0d grants exp 2", seen); end
    @(posedge clk); #2;
    mask[1] = 1'b1;
    @(negedge clk);
    n_cmp++; if (gnt !== '0) begin n_err++; $display("FAIL drop_gnt got %b exp 0000", gnt); end
    @(posedge clk); #2;
    mask[1] = 1'b0;
    hit = 0;
    for (int t = 0; t < 10 && !hit; t++) begin
      @(negedge clk);
      if (gnt !== '0) begin
        hit = 1;
        n_cmp++;
        if (gnt !== 4'b1000 || fifo_data_in !== 8'h30) begin
          n_err++; $display("FAIL drop_next got gnt=%b data=%h exp gnt=1000 data=30", gnt, fifo_data_in);
        end
      end
    end
    n_cmp++; if (!hit) begin n_err++; $display("FAIL drop_next_timeout got none exp gnt"); end
  endtask

  task automatic test_reset_mid_burst();
    bit hit;
    do_reset();
    @(posedge clk); #2;
    for (int k = 0; k < 6; k++) push(1, 8'h10 + 8'(k));
    for (int k = 0; k < 6; k++) push(3, 8'h60 + 8'(k));
    hit = 0;
    for (int t = 0; t < 30 && !hit; t++) begin
      @(negedge clk);
      if (gnt[3]) hit = 1;
    end
    n_cmp++; if (!hit) begin n_err++; $display("FAIL mid_wait_timeout got none exp gnt[3]"); end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (gnt !== '0) begin n_err++; $display("FAIL mid_gnt got %b exp 0000", gnt); end
    n_cmp++; if (fifo_wr_en !== 1'b0) begin n_err++; $display("FAIL mid_wr_en got %b exp 0", fifo_wr_en); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_busy got %b exp 0", busy); end
    n_cmp++; if (occupancy !== '0) begin n_err++; $display("FAIL mid_occ got %0d exp 0", occupancy); end
    @(posedge clk); #2;
    rst = 1'b0;
    hit = 0;
    for (int t = 0; t < 10 && !hit; t++) begin
      @(negedge clk);
      if (gnt !== '0) begin
        hit = 1;
        n_cmp++;
        if (gnt !== 4'b0010 || fifo_data_in !== 8'h14) begin
          n_err++; $display("FAIL mid_restart got gnt=%b data=%h exp gnt=0010 data=14", gnt, fifo_data_in);
        end
      end
    end
    n_cmp++; if (!hit) begin n_err++; $display("FAIL mid_restart_timeout got none exp gnt"); end
  endtask

  task automatic test_random();
    int i;
    do_reset();
    for (int c = 0; c < 500; c++) begin
      @(posedge clk); #2;
      if ($urandom_range(0, 2) == 0) begin
        i = $urandom_range(0, N - 1);
        if (src_q[i].size() < 6) push(i, 8'($urandom_range(0, 255)));
      end
      for (int r = 0; r < N; r++) mask[r] = ($urandom_range(0, 15) == 0);
      fifo_empty = (m_occ == 0);
      fifo_rd_en = ($urandom_range(0, 2) == 0);
    end
    @(posedge clk); #2;
    mask = '0; fifo_rd_en = 1'b0;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_single_burst();
    test_full_stall();
    test_rw_same_cycle();
    test_drop();
    test_reset_mid_burst();
    test_random();
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Shares one synchronous FIFO write port (WIDTH-bit data, DEPTH entries) among N_REQ producers.
- Round-robin arbitration with bounded bursts.
- Keeps its own occupancy shadow count, so no write is ever issued into a full FIFO; the FIFO's registered full flag lags by one cycle.
- Sits between producer blocks and the FIFO's wr_en/data_in. Observes the consumer's rd_en and the FIFO's empty flag.

Parameters:
N_REQ, 4, number of requesters (2..8)
WIDTH, 8, data width; must equal the FIFO width
DEPTH, 8, FIFO depth; must equal the FIFO depth
MAX_BURST, 4, maximum beats per grant (1..15)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
req  in  N_REQ  per-requester write request; data is held stable while req is high and not granted
req_data  in  N_REQ*WIDTH  requester i data at [i*WIDTH +: WIDTH]
gnt  out  N_REQ  one-hot; high in the cycle requester i's beat is accepted
fifo_wr_en  out  1  to FIFO wr_en
fifo_data_in  out  WIDTH  to FIFO data_in
fifo_rd_en  in  1  copy of the consumer's FIFO rd_en
fifo_empty  in  1  FIFO empty flag
occupancy  out  $clog2(DEPTH+1)  shadow entry count
busy  out  1  high while in state BURST

Behaviour:
- Reset: asynchronous. While rst is high, all outputs are 0 (fifo_data_in = 0, occupancy = 0), state = IDLE, owner = 0, rr_ptr = 0, beats = 0.
- rst is shared with the FIFO and is held for at least one clk edge, so the FIFO's synchronous reset also takes effect.
- FSM states: IDLE, BURST.
- IDLE:
  - If |req: owner <= first i with req[i], searching rr_ptr, rr_ptr+1, ... mod N_REQ; beats <= 0; go to BURST.
  - No transfer occurs in the IDLE cycle (one-cycle arbitration bubble).
- BURST:
  - accept = req[owner] && (occupancy < DEPTH).
  - accept is combinational from registered state plus req.
  - When accept is high: gnt[owner] = 1, fifo_wr_en = 1, fifo_data_in = req_data[owner]. Otherwise gnt = 0, fifo_wr_en = 0, fifo_data_in = 0.
  - On accept: beats <= beats+1.
  - Exit to IDLE with rr_ptr <= (owner+1) mod N_REQ when either:
    - (accept && beats == MAX_BURST-1), or
    - !req[owner] (requester dropped; no beat that cycle).
  - occupancy == DEPTH with req[owner] held: stay in BURST and stall. No timeout; other requesters wait.
- Occupancy update:
  - inc = fifo_wr_en; dec = fifo_rd_en && !fifo_empty.
  - Both high: unchanged. inc only: +1. dec only: -1.
  - Never exceeds DEPTH and never underflows (dec is qualified by empty).
- Fairness: each requester waits at most (N_REQ-1)*(MAX_BURST+1) non-stalled cycles after the current burst ends.
- A requester dropping req mid-burst loses the remainder of its burst and rotates to the back.
- Reset mid-burst: gnt and fifo_wr_en fall immediately (asynchronous); the partial burst is abandoned.

Optional Feature:
FIFO_ARB_STATS_EN
- Defined: adds outputs wr_beats (16 bits, saturating count of accepted beats) and full_stalls (16 bits, saturating count of BURST cycles with req[owner] && occupancy == DEPTH). Both reset to 0.
- Undefined: neither port nor counters exist; the rest of the behaviour is identical.

Decomposition:
- Package fifo_arb_pkg: state enum (IDLE, BURST); localparams OCC_W = $clog2(DEPTH+1), PTR_W = $clog2(N_REQ), BEAT_W = 4.
- Sub-module rr_pick: combinational priority search given req and rr_ptr, returns index and valid. Reusable by other arbiters.

Test Plan:
- Only req[2] high, data 0xA0..0xA5 presented per beat -> IDLE bubble, then 4 accepted beats (0xA0..0xA3); return to IDLE, bubble, regrant to 2 for 0xA4, 0xA5.
- req = 4'b1111 held, no reads -> grants in order 0,1 (4 beats each); occupancy reaches 8; fifo_wr_en held low, busy high, owner stays 2 with gnt = 0.
- From the full state, pulse fifo_rd_en once -> occupancy 8->7, next cycle one beat from requester 2 accepted, occupancy back to 8; FIFO full never violated.
- Occupancy 3, simultaneous accepted write and fifo_rd_en with fifo_empty = 0 -> occupancy stays 3. fifo_rd_en with fifo_empty = 1 and no write -> occupancy unchanged.
- Requester 1 drops req after 2 beats -> return to IDLE, rr_ptr = 2; requester 3 (pending) granted next, not 1.
- Assert rst asynchronously mid-burst (between edges) -> gnt, fifo_wr_en, busy and occupancy go to 0 before the next edge; after release, arbitration restarts at requester 0.
